// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B/index generator that walks an emulated position toward a
// signed target, one count per STEP_DIV-cycle tick.
module quad_encoder_emulator #(
    parameter int WIDTH    = 24,
    parameter int STEP_DIV = 100,
    parameter int CPR      = 2048
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] target,
    input  logic                    load,
    output logic                    quadA,
    output logic                    quadB,
    output logic                    index,
    output logic signed [WIDTH-1:0] position,
    output logic                    busy
);
    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int PW = $clog2(CPR);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CPR - 1);

    logic [TW-1:0]          timer;
    logic [PW-1:0]          phase;
    logic                   tick;
    logic signed [WIDTH:0]  diff;
    logic                   step_fwd;
    logic                   step_rev;
    logic signed [WIDTH-1:0] pos_nxt;
    logic [PW-1:0]          phase_nxt;
    logic                   a_nxt;
    logic                   b_nxt;

    always_comb begin
        tick = enable && (timer == TIMER_LAST);
        // Sign-extended difference keeps the compare correct at the extremes
        diff = {target[WIDTH-1], target} - {position[WIDTH-1], position};
        step_fwd = tick && !diff[WIDTH] && (diff != '0);
        step_rev = tick && diff[WIDTH];

        pos_nxt   = position;
        phase_nxt = phase;
        a_nxt     = quadA;
        b_nxt     = quadB;
        if (load) begin
            pos_nxt   = target;
            phase_nxt = '0;
        end else if (step_fwd) begin
            pos_nxt   = position + 1'b1;
            phase_nxt = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            // 00 -> 10 -> 11 -> 01 -> 00 : A leads B
            unique case ({quadA, quadB})
                2'b00: begin a_nxt = 1'b1; b_nxt = 1'b0; end
                2'b10: begin a_nxt = 1'b1; b_nxt = 1'b1; end
                2'b11: begin a_nxt = 1'b0; b_nxt = 1'b1; end
                default: begin a_nxt = 1'b0; b_nxt = 1'b0; end
            endcase
        end else if (step_rev) begin
            pos_nxt   = position - 1'b1;
            phase_nxt = (phase == '0) ? PHASE_LAST : phase - 1'b1;
            unique case ({quadA, quadB})
                2'b00: begin a_nxt = 1'b0; b_nxt = 1'b1; end
                2'b01: begin a_nxt = 1'b1; b_nxt = 1'b1; end
                2'b11: begin a_nxt = 1'b1; b_nxt = 1'b0; end
                default: begin a_nxt = 1'b0; b_nxt = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            timer    <= '0;
            phase    <= '0;
            position <= '0;
            quadA    <= 1'b0;
            quadB    <= 1'b0;
            index    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (load || !enable || tick)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            // All observable outputs move together on the same edge
            phase    <= phase_nxt;
            position <= pos_nxt;
            quadA    <= a_nxt;
            quadB    <= b_nxt;
            index    <= (phase_nxt == '0);
            busy     <= enable && (pos_nxt != target);
        end
    end
endmodule
